// File: rtl/score_keeper_if.sv
// Signal bundle between the pong ball/pause logic and the score keeper.
// The slave modport is the score keeper side; the master modport is the upstream/driver side.
interface score_keeper_if #(
   parameter int SCORE_WIDTH = 4
);
   logic                   pause;
   logic [1:0]             win;
   logic                   new_game;
   logic [SCORE_WIDTH-1:0] score1;
   logic [SCORE_WIDTH-1:0] score2;
   logic [1:0]             winner;
   logic                   game_over;
   logic                   freeze;
   logic                   serve_req;

   modport master (
      output pause, win, new_game,
      input  score1, score2, winner, game_over, freeze, serve_req
   );

   modport slave (
      input  pause, win, new_game,
      output score1, score2, winner, game_over, freeze, serve_req
   );
endinterface

// File: rtl/score_keeper.sv
// Pong score keeper: counts points from the ball's win level, sequences
// point hold / re-serve / game-over, and drives freeze and serve requests.
module score_keeper #(
   parameter int SCORE_WIDTH = 4,
   parameter int WIN_SCORE   = 7,
   parameter int HOLD_CYCLES = 60,
   parameter int HOLD_WIDTH  = 8
) (
   input logic           clk,
   input logic           rst,
   score_keeper_if.slave sk
);
   typedef enum logic [1:0] {PLAY, HOLD, GAME_OVER} state_t;

   localparam logic [SCORE_WIDTH-1:0] WIN_VAL   = SCORE_WIDTH'(WIN_SCORE);
   localparam logic [HOLD_WIDTH-1:0]  HOLD_LOAD = HOLD_WIDTH'(HOLD_CYCLES - 1);

   state_t                 state_q;
   logic [HOLD_WIDTH-1:0]  hold_cnt_q;
   logic                   armed_q;
   logic [SCORE_WIDTH-1:0] score1_q, score2_q;
   logic [1:0]             winner_q;
   logic                   game_over_q, freeze_q, serve_req_q;

   logic [SCORE_WIDTH-1:0] score1_d, score2_d;
   logic                   p1_evt, p2_evt;

   // The win level is held until re-serve, so only the first armed sample counts.
   assign p1_evt = armed_q && (sk.win == 2'b01);
   assign p2_evt = armed_q && (sk.win == 2'b10);

   assign score1_d = (score1_q == WIN_VAL) ? score1_q : score1_q + 1'b1;
   assign score2_d = (score2_q == WIN_VAL) ? score2_q : score2_q + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= PLAY;
         hold_cnt_q  <= '0;
         armed_q     <= 1'b1;
         score1_q    <= '0;
         score2_q    <= '0;
         winner_q    <= 2'b00;
         game_over_q <= 1'b0;
         freeze_q    <= 1'b0;
         serve_req_q <= 1'b0;
      end else begin
         serve_req_q <= 1'b0;
         if (sk.win == 2'b00) begin
            armed_q <= 1'b1;
         end
         case (state_q)
            PLAY: begin
               if (p1_evt || p2_evt) begin
                  armed_q  <= 1'b0;
                  freeze_q <= 1'b1;
                  if (p1_evt) begin
                     score1_q <= score1_d;
                  end else begin
                     score2_q <= score2_d;
                  end
                  if ((p1_evt && score1_d == WIN_VAL) || (p2_evt && score2_d == WIN_VAL)) begin
                     state_q     <= GAME_OVER;
                     winner_q    <= p1_evt ? 2'b01 : 2'b10;
                     game_over_q <= 1'b1;
                  end else begin
                     state_q    <= HOLD;
                     hold_cnt_q <= HOLD_LOAD;
                  end
               end
            end
            HOLD: begin
               if (!sk.pause) begin
                  if (hold_cnt_q == '0) begin
                     state_q     <= PLAY;
                     freeze_q    <= 1'b0;
                     serve_req_q <= 1'b1;
                  end else begin
                     hold_cnt_q <= hold_cnt_q - 1'b1;
                  end
               end
            end
            GAME_OVER: begin
               if (sk.new_game) begin
                  score1_q    <= '0;
                  score2_q    <= '0;
                  winner_q    <= 2'b00;
                  game_over_q <= 1'b0;
                  freeze_q    <= 1'b1;
                  state_q     <= HOLD;
                  hold_cnt_q  <= HOLD_LOAD;
               end
            end
            default: begin
               state_q <= PLAY;
            end
         endcase
      end
   end

   assign sk.score1    = score1_q;
   assign sk.score2    = score2_q;
   assign sk.winner    = winner_q;
   assign sk.game_over = game_over_q;
   assign sk.freeze    = freeze_q;
   assign sk.serve_req = serve_req_q;
endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with WIN_SCORE=3, HOLD_CYCLES=4: a cycle-by-cycle
// vector table plus hand sequences for reset behaviour.
module tb_score_keeper;
   localparam int SW = 4;

   typedef struct packed {
      logic          pause;
      logic [1:0]    win;
      logic          new_game;
      logic [SW-1:0] s1;
      logic [SW-1:0] s2;
      logic [1:0]    wn;
      logic          go;
      logic          fr;
      logic          sr;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   score_keeper_if #(.SCORE_WIDTH(SW)) sk ();

   score_keeper #(
      .SCORE_WIDTH(SW),
      .WIN_SCORE  (3),
      .HOLD_CYCLES(4),
      .HOLD_WIDTH (8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .sk (sk)
   );

   int   n_checks = 0;
   int   n_pass   = 0;
   vec_t vecs[$];

   function automatic logic [2*SW+4:0] outs();
      return {sk.score1, sk.score2, sk.winner, sk.game_over, sk.freeze, sk.serve_req};
   endfunction

   task automatic check(input string name, input logic [2*SW+4:0] got, input logic [2*SW+4:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
         $display("%s: ok {s1,s2,winner,go,freeze,serve}=%h", name, got);
      end else begin
         $display("FAIL %s: got {s1,s2,winner,go,freeze,serve}=%h required %h", name, got, exp);
      end
   endtask

   task automatic add(input logic p, input logic [1:0] w, input logic ng,
                      input int s1, input int s2, input logic [1:0] wn,
                      input logic go, input logic fr, input logic sr);
      vec_t v;
      v.pause = p; v.win = w; v.new_game = ng;
      v.s1 = SW'(s1); v.s2 = SW'(s2); v.wn = wn;
      v.go = go; v.fr = fr; v.sr = sr;
      vecs.push_back(v);
   endtask

   initial begin
      // Scenario A: win=01 held for 20 cycles scores once, freeze 4 cycles, then serve.
      add(0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 0);
      add(0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 0);
      add(0, 2'd1, 0, 1, 0, 2'd0, 0, 1, 0);
      for (int i = 0; i < 3; i++) add(0, 2'd1, 0, 1, 0, 2'd0, 0, 1, 0);
      add(0, 2'd1, 0, 1, 0, 2'd0, 0, 0, 1);
      for (int i = 0; i < 15; i++) add(0, 2'd1, 0, 1, 0, 2'd0, 0, 0, 0);
      add(0, 2'd0, 0, 1, 0, 2'd0, 0, 0, 0);
      // Scenario B: three player-2 points end the game with no serve.
      for (int k = 1; k <= 2; k++) begin
         add(0, 2'd2, 0, 1, k, 2'd0, 0, 1, 0);
         for (int i = 0; i < 3; i++) add(0, 2'd0, 0, 1, k, 2'd0, 0, 1, 0);
         add(0, 2'd0, 0, 1, k, 2'd0, 0, 0, 1);
      end
      add(0, 2'd2, 0, 1, 3, 2'd2, 1, 1, 0);
      add(0, 2'd0, 0, 1, 3, 2'd2, 1, 1, 0);
      // Scenario C: win and pause ignored in GAME_OVER, new_game restarts via HOLD.
      add(1, 2'd1, 0, 1, 3, 2'd2, 1, 1, 0);
      add(1, 2'd1, 0, 1, 3, 2'd2, 1, 1, 0);
      add(0, 2'd0, 1, 0, 0, 2'd0, 0, 1, 0);
      for (int i = 0; i < 3; i++) add(0, 2'd0, 0, 0, 0, 2'd0, 0, 1, 0);
      add(0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 1);
      add(0, 2'd0, 1, 0, 0, 2'd0, 0, 0, 0);
      // Scenario D: pause for 10 cycles from the second HOLD cycle stretches freeze to 14.
      add(0, 2'd1, 0, 1, 0, 2'd0, 0, 1, 0);
      add(0, 2'd0, 0, 1, 0, 2'd0, 0, 1, 0);
      for (int i = 0; i < 10; i++) add(1, 2'd0, 0, 1, 0, 2'd0, 0, 1, 0);
      add(0, 2'd0, 0, 1, 0, 2'd0, 0, 1, 0);
      add(0, 2'd0, 0, 1, 0, 2'd0, 0, 1, 0);
      add(0, 2'd0, 0, 1, 0, 2'd0, 0, 0, 1);
      // Scenario E: illegal win=11 ignored, then a normal point.
      for (int i = 0; i < 5; i++) add(0, 2'd3, 0, 1, 0, 2'd0, 0, 0, 0);
      add(0, 2'd0, 0, 1, 0, 2'd0, 0, 0, 0);
      add(0, 2'd1, 0, 2, 0, 2'd0, 0, 1, 0);
      add(0, 2'd0, 0, 2, 0, 2'd0, 0, 1, 0);

      sk.pause = 1'b0; sk.win = 2'd0; sk.new_game = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset", outs(), '0);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         sk.pause    = vecs[i].pause;
         sk.win      = vecs[i].win;
         sk.new_game = vecs[i].new_game;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d", i), outs(),
               {vecs[i].s1, vecs[i].s2, vecs[i].wn, vecs[i].go, vecs[i].fr, vecs[i].sr});
      end

      // Scenario F: reset mid-HOLD with score1=2 clears everything and never serves.
      sk.win = 2'd0; sk.pause = 1'b0; sk.new_game = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_in_hold", outs(), '0);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("post_rst%0d", i), outs(), '0);
      end
      sk.win = 2'd1;
      @(posedge clk);
      #1;
      check("post_rst_point", outs(), {SW'(1), SW'(0), 2'd0, 1'b0, 1'b1, 1'b0});
      sk.win = 2'd0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Downstream stage of the pong top level. Consumes the ball's 2-bit win indication and keeps both players' scores.
- Sequences the point / re-serve / game-over flow.
- Drives a freeze request, combined upstream with the pause button.
- Issues a one-cycle serve request that re-centres the ball.
- Exposes scores and the winner for the graphics driver.

Parameters:
- SCORE_WIDTH, 4, width of each score counter.
- WIN_SCORE, 7, score that ends the game (1..2^SCORE_WIDTH-1).
- HOLD_CYCLES, 60, cycles of freeze after a point before re-serve (>=1).
- HOLD_WIDTH, 8, width of the hold counter (2^HOLD_WIDTH > HOLD_CYCLES).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- pause, input, 1, user pause; stalls the hold countdown.
- win, input, 2, bit0 = player1 scored, bit1 = player2 scored; level, held until ball re-serve.
- new_game, input, 1, restart request; honoured only in GAME_OVER.
- score1, output, SCORE_WIDTH, player1 score.
- score2, output, SCORE_WIDTH, player2 score.
- winner, output, 2, 01 = player1 won, 10 = player2 won, 00 = none.
- game_over, output, 1, high while in GAME_OVER.
- freeze, output, 1, high in HOLD and GAME_OVER.
- serve_req, output, 1, one-cycle pulse requesting ball re-serve.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- All outputs are registered.
- Reset values: score1 = score2 = 0, winner = 00, game_over = 0, freeze = 0, serve_req = 0, state = PLAY, hold counter = 0, armed = 1.
- Reset mid-HOLD or mid-GAME_OVER returns to PLAY next cycle with all outputs cleared.
- States: PLAY, HOLD, GAME_OVER.
- Point event:
  - Armed = 1 and win is 01 or 10 in PLAY.
  - Clear armed on the event. Re-set armed only after win samples 00.
  - A win level held for many cycles therefore scores exactly once.
  - win = 11 is illegal: ignored, no score change, armed unchanged.
  - win nonzero outside PLAY is ignored.
- PLAY, event at cycle N:
  - The scorer's count increments at N+1.
  - If the new value equals WIN_SCORE: go to GAME_OVER at N+1, winner latched (01/10), game_over = 1, freeze = 1.
  - Otherwise: go to HOLD at N+1 with freeze = 1 and hold counter = HOLD_CYCLES-1.
  - Scores saturate at WIN_SCORE and never wrap.
- HOLD:
  - Each cycle with pause = 0: if counter = 0, go to PLAY next cycle with freeze = 0 and serve_req = 1 for that one cycle; else decrement.
  - With pause = 1: counter holds and freeze stays 1.
  - Net effect: freeze is high for exactly HOLD_CYCLES non-paused cycles.
- GAME_OVER:
  - freeze = 1. win and pause are ignored.
  - new_game = 1 at cycle M: at M+1, scores = 0, winner = 00, game_over = 0, go to HOLD with counter = HOLD_CYCLES-1 and freeze = 1.
  - Re-serve then follows the normal HOLD rule.
- serve_req is never asserted in the same cycle as a score change. It is always exactly one cycle wide.
- new_game outside GAME_OVER has no effect.
- pause has no effect on PLAY scoring; the ball does not move while paused, so win does not change.

Test Plan (WIN_SCORE = 3, HOLD_CYCLES = 4):
- Reset 2 cycles then release: all outputs 0 and state PLAY. Drive win = 01 at cycle 10, held for 20 cycles: score1 = 1 at cycle 11 and stays 1 (single count). freeze high on cycles 11-14. serve_req high on cycle 15 only.
- win = 10 pulses, each followed by win = 00 and the HOLD completing, three times: score2 goes 1, 2, 3. On the third point, game_over = 1, winner = 10 and freeze = 1 in the same cycle the score reaches 3. No serve_req.
- In GAME_OVER, drive win = 01 and then new_game: the win is ignored (score1 unchanged). On new_game at cycle M, at M+1 both scores = 0, winner = 00, game_over = 0, freeze = 1. serve_req at M+5.
- Point scored, then pause = 1 for 10 cycles starting in the second HOLD cycle: freeze stays high for 4 + 10 cycles total. serve_req occurs 1 cycle after the 4th non-paused hold cycle.
- win = 11 for 5 cycles in PLAY: no score change, freeze stays 0. Then win = 00 followed by 01: score1 increments normally.
- Assert rst during HOLD with score1 = 2: next cycle all outputs are 0, state PLAY, and no serve_req is emitted.
